// File: rtl/jpeg_huff_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_huff_pkg
// Shared types and constants for the JPEG Huffman encoder.
//   huff_ent_t    : one Huffman table entry {code[15:0], len[4:0]}
//   chk_state_t   : block-protocol checker states (used when JPEG_HUFF_CHK_EN)
//   amp_bits()    : JPEG amplitude bit formatting for a (size, amp) pair
// ---------------------------------------------------------------------------
package jpeg_huff_pkg;

    localparam int MAX_CODE_LEN = 16;
    localparam int MAX_AMP_BITS = 11;
    localparam int HCODE_W      = MAX_CODE_LEN + MAX_AMP_BITS;  // 27

    localparam logic TBL_DC = 1'b0;
    localparam logic TBL_AC = 1'b1;

    // Largest legal magnitude category for each coefficient class.
    localparam logic [3:0] DC_MAX_SIZE = 4'd11;
    localparam logic [3:0] AC_MAX_SIZE = 4'd10;

    typedef struct packed {
        logic [MAX_CODE_LEN-1:0] code;
        logic [4:0]              len;
    } huff_ent_t;

    typedef enum logic [0:0] {
        WAIT_DC = 1'b0,
        IN_BLK  = 1'b1
    } chk_state_t;

    // Negative amplitudes are sent as the low `size` bits of (amp - 1),
    // i.e. the one's complement of |amp|. size must already be clamped to 11.
    function automatic logic [MAX_AMP_BITS-1:0] amp_bits(
        input logic [11:0] amp,
        input logic [3:0]  size
    );
        logic [11:0]             v;
        logic [MAX_AMP_BITS-1:0] mask;
        v    = amp[11] ? (amp - 12'd1) : amp;
        mask = ~({MAX_AMP_BITS{1'b1}} << size);
        return v[MAX_AMP_BITS-1:0] & mask;
    endfunction

endpackage

// File: rtl/jpeg_huff_tbl.sv
// ---------------------------------------------------------------------------
// jpeg_huff_tbl
// DC (16 entries) and AC (256 entries) Huffman code tables with one
// synchronous write port and one registered read port. The read register is
// pipeline stage 1 of the encoder.
//   clk      : system clock
//   ena      : clock enable; gates both write and read
//   i_we     : write strobe,  i_wsel selects DC/AC, i_waddr, i_went = entry
//   i_re     : read strobe,   i_rsel selects DC/AC, i_raddr
//   o_rent   : registered read data (valid one enabled cycle after i_re)
// ---------------------------------------------------------------------------
module jpeg_huff_tbl
    import jpeg_huff_pkg::*;
(
    input  logic       clk,
    input  logic       ena,
    input  logic       i_we,
    input  logic       i_wsel,
    input  logic [7:0] i_waddr,
    input  huff_ent_t  i_went,
    input  logic       i_re,
    input  logic       i_rsel,
    input  logic [7:0] i_raddr,
    output huff_ent_t  o_rent
);

    huff_ent_t r_dc_mem [16];
    huff_ent_t r_ac_mem [256];
    huff_ent_t r_rent;

    // NOTE: table storage and its read register have no reset; contents are
    // loaded by software and the read data is qualified by a pipeline valid.
    // A read and a write to the same entry in one cycle returns the old entry
    // because both sample the array before the edge.
    always_ff @(posedge clk) begin
        if (ena) begin
            if (i_we) begin
                if (i_wsel == TBL_DC) r_dc_mem[i_waddr[3:0]] <= i_went;
                else                  r_ac_mem[i_waddr]      <= i_went;
            end
            if (i_re) begin
                r_rent <= (i_rsel == TBL_DC) ? r_dc_mem[i_raddr[3:0]]
                                             : r_ac_mem[i_raddr];
            end
        end
    end

    assign o_rent = r_rent;

endmodule

// File: rtl/jpeg_huff_enc.sv
// ---------------------------------------------------------------------------
// jpeg_huff_enc
// JPEG baseline Huffman encoder: turns (size, rlen, amp) symbols from the
// run-length stage into right-aligned {code, amplitude bits} words.
// Two enabled cycles of latency, one symbol per enabled cycle.
//   clk, rst (async, active low), ena (clock enable)
//   size/rlen/amp, den, bstart          : input symbol
//   tbl_we/tbl_sel/tbl_addr/tbl_code/tbl_len : table write port
//   hcode/hlen/hvalid/hblk               : encoded word
//   err                                  : sticky protocol error
// Build option: define JPEG_HUFF_CHK_EN to include the block-protocol checker
// (WAIT_DC/IN_BLK FSM with a 6-bit coefficient index).
// ---------------------------------------------------------------------------
module jpeg_huff_enc
    import jpeg_huff_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [3:0]         size,
    input  logic [3:0]         rlen,
    input  logic [11:0]        amp,
    input  logic               den,
    input  logic               bstart,
    input  logic               tbl_we,
    input  logic               tbl_sel,
    input  logic [7:0]         tbl_addr,
    input  logic [15:0]        tbl_code,
    input  logic [4:0]         tbl_len,
    output logic [HCODE_W-1:0] hcode,
    output logic [4:0]         hlen,
    output logic               hvalid,
    output logic               hblk,
    output logic               err
);

    // ---------------- stage 0: address, size check, checker ----------------
    logic       w_is_dc;
    logic       w_size_err;
    logic [3:0] w_size_cl;
    logic       w_rd_sel;
    logic [7:0] w_rd_addr;
    logic       w_chk_err;

    // The DC table is chosen by bstart alone; with the checker enabled a
    // symbol without bstart in WAIT_DC is flagged but still encoded as AC.
    assign w_is_dc    = bstart;
    assign w_size_err = size > (w_is_dc ? DC_MAX_SIZE : AC_MAX_SIZE);
    assign w_size_cl  = (size > DC_MAX_SIZE) ? DC_MAX_SIZE : size;
    assign w_rd_sel   = w_is_dc ? TBL_DC : TBL_AC;
    assign w_rd_addr  = w_is_dc ? {4'h0, size} : {rlen, size};

`ifdef JPEG_HUFF_CHK_EN
    chk_state_t r_state;
    logic [5:0] r_idx;
    logic [6:0] w_idx_sum;
    logic       w_is_eob;

    assign w_idx_sum = {1'b0, r_idx} + {3'b000, rlen} + 7'd1;
    assign w_is_eob  = (rlen == 4'd0) && (size == 4'd0);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_chk_err = 1'b0;
        if (r_state == WAIT_DC) w_chk_err = !bstart;
        else                    w_chk_err = bstart || (!w_is_eob && (w_idx_sum > 7'd63));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_DC;
            r_idx   <= 6'd0;
        end else if (ena && den) begin
            case (r_state)
                WAIT_DC: begin
                    if (bstart) begin
                        r_state <= IN_BLK;
                        r_idx   <= 6'd0;
                    end
                end
                IN_BLK: begin
                    if (bstart) begin
                        r_idx <= 6'd0;               // restart, flagged above
                    end else if (w_is_eob || (w_idx_sum >= 7'd63)) begin
                        r_state <= WAIT_DC;          // block complete or overrun
                        r_idx   <= 6'd0;
                    end else begin
                        r_idx <= w_idx_sum[5:0];
                    end
                end
                default: begin
                    r_state <= WAIT_DC;
                    r_idx   <= 6'd0;
                end
            endcase
        end
    end
`else
    assign w_chk_err = 1'b0;
`endif

    // ---------------- stage 1: table read + side-band pipeline -------------
    huff_ent_t  w_ent;
    huff_ent_t  w_went;
    logic       r_s1_valid;
    logic       r_s1_blk;
    logic       r_s1_err;
    logic [3:0] r_s1_size;
    logic [11:0] r_s1_amp;

    assign w_went = '{code: tbl_code, len: tbl_len};

    jpeg_huff_tbl u_tbl (
        .clk     (clk),
        .ena     (ena),
        .i_we    (tbl_we),
        .i_wsel  (tbl_sel),
        .i_waddr (tbl_addr),
        .i_went  (w_went),
        .i_re    (den),
        .i_rsel  (w_rd_sel),
        .i_raddr (w_rd_addr),
        .o_rent  (w_ent)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_blk   <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_size  <= 4'd0;
            r_s1_amp   <= 12'd0;
        end else if (ena) begin
            r_s1_valid <= den;
            if (den) begin
                r_s1_blk  <= bstart;
                r_s1_err  <= w_size_err || w_chk_err;
                r_s1_size <= w_size_cl;
                r_s1_amp  <= amp;
            end
        end
    end

    // ---------------- stage 2: amplitude format + concatenation ------------
    logic [4:0]              w_len_cl;
    logic [MAX_CODE_LEN-1:0] w_code_mask;
    logic [MAX_AMP_BITS-1:0] w_amp;
    logic [HCODE_W-1:0]      w_hcode;
    logic [4:0]              w_hlen;
    logic                    w_len_zero;

    // Lengths beyond 16 cannot be represented; clamp so hlen stays <= 27.
    assign w_len_cl    = (w_ent.len > 5'(MAX_CODE_LEN)) ? 5'(MAX_CODE_LEN) : w_ent.len;
    assign w_code_mask = ~({MAX_CODE_LEN{1'b1}} << w_len_cl);
    assign w_amp       = amp_bits(r_s1_amp, r_s1_size);
    assign w_hcode     = ({{MAX_AMP_BITS{1'b0}}, w_ent.code & w_code_mask} << r_s1_size)
                       | {{MAX_CODE_LEN{1'b0}}, w_amp};
    assign w_hlen      = w_len_cl + {1'b0, r_s1_size};
    assign w_len_zero  = (w_ent.len == 5'd0);

    logic [HCODE_W-1:0] r_hcode;
    logic [4:0]         r_hlen;
    logic               r_hvalid;
    logic               r_hblk;
    logic               r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcode  <= '0;
            r_hlen   <= 5'd0;
            r_hvalid <= 1'b0;
            r_hblk   <= 1'b0;
            r_err    <= 1'b0;
        end else if (ena) begin
            r_hvalid <= r_s1_valid;
            r_hblk   <= r_s1_valid && r_s1_blk;
            r_hcode  <= r_s1_valid ? w_hcode : '0;
            r_hlen   <= r_s1_valid ? w_hlen  : 5'd0;
            // err rises together with the offending word and stays set.
            if (r_s1_valid && (r_s1_err || w_len_zero)) r_err <= 1'b1;
        end
    end

    assign hcode  = r_hcode;
    assign hlen   = r_hlen;
    assign hvalid = r_hvalid;
    assign hblk   = r_hblk;
    assign err    = r_err;

endmodule

// File: tb/tb_jpeg_huff_enc.sv
// ---------------------------------------------------------------------------
// tb_jpeg_huff_enc
// Directed, table-driven bench for jpeg_huff_enc. Symbols are held in a queue
// of records with hand-computed expected words; a streaming task applies them
// back to back (optionally with a clock-enable stall) and compares each
// emitted word in order. Error, clamp, checker and reset cases follow.
// ---------------------------------------------------------------------------
module tb_jpeg_huff_enc;
    import jpeg_huff_pkg::*;

`ifdef JPEG_HUFF_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ena, den, bstart, tbl_we, tbl_sel;
    logic [3:0]  size, rlen;
    logic [11:0] amp;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_code;
    logic [4:0]  tbl_len;
    logic [26:0] hcode;
    logic [4:0]  hlen;
    logic        hvalid, hblk, err;

    jpeg_huff_enc dut (
        .clk(clk), .rst(rst), .ena(ena), .size(size), .rlen(rlen), .amp(amp),
        .den(den), .bstart(bstart), .tbl_we(tbl_we), .tbl_sel(tbl_sel),
        .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
        .hcode(hcode), .hlen(hlen), .hvalid(hvalid), .hblk(hblk), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        bstart;
        logic [3:0]  rlen;
        logic [3:0]  size;
        logic [11:0] amp;
        logic        tw;        // table write in the same cycle
        logic [7:0]  tw_addr;
        logic [15:0] tw_code;
        logic [4:0]  tw_len;
        logic [26:0] exp_code;
        logic [4:0]  exp_len;
        logic        exp_blk;
        logic        exp_err;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(input logic bs, input int rl, input int sz, input int am,
                                input int ec, input int el, input logic ee);
        vec_t v;
        v.bstart = bs;     v.rlen = rl[3:0];  v.size = sz[3:0];  v.amp = am[11:0];
        v.tw = 1'b0;       v.tw_addr = 8'h00; v.tw_code = 16'h0; v.tw_len = 5'd0;
        v.exp_code = ec[26:0]; v.exp_len = el[4:0]; v.exp_blk = bs; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [7:0] addr, input logic [15:0] code,
                        input logic [4:0] len);
        @(negedge clk);
        tbl_we = 1'b1; tbl_sel = sel; tbl_addr = addr; tbl_code = code; tbl_len = len;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic idle_inputs();
        den = 1'b0; bstart = 1'b0; tbl_we = 1'b0;
    endtask

    // Plays q back to back; ena is low for stall_len cycles from stall_at.
    task automatic run_stream(input string tag, input int stall_at, input int stall_len);
        int          n = q.size();
        int          sent = 0, got = 0, cyc = 0;
        logic [26:0] h_code = '0;
        logic [4:0]  h_len  = '0;
        logic        h_vld  = 1'b0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            ena = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                den = 1'b1; bstart = q[sent].bstart; rlen = q[sent].rlen;
                size = q[sent].size; amp = q[sent].amp;
                tbl_we = q[sent].tw; tbl_sel = TBL_AC; tbl_addr = q[sent].tw_addr;
                tbl_code = q[sent].tw_code; tbl_len = q[sent].tw_len;
            end else begin
                idle_inputs();
            end
            @(posedge clk); #1;
            if (ena) begin
                if (sent < n) sent++;
                if (hvalid) begin
                    check($sformatf("%s.w%0d.hcode", tag, got), 32'(hcode), 32'(q[got].exp_code));
                    check($sformatf("%s.w%0d.hlen",  tag, got), 32'(hlen),  32'(q[got].exp_len));
                    check($sformatf("%s.w%0d.hblk",  tag, got), 32'(hblk),  32'(q[got].exp_blk));
                    check($sformatf("%s.w%0d.err",   tag, got), 32'(err),   32'(q[got].exp_err));
                    got++;
                end
                h_code = hcode; h_len = hlen; h_vld = hvalid;
            end else begin
                check($sformatf("%s.hold_hcode", tag), 32'(hcode),  32'(h_code));
                check($sformatf("%s.hold_hlen",  tag), 32'(hlen),   32'(h_len));
                check($sformatf("%s.hold_hvalid",tag), 32'(hvalid), 32'(h_vld));
            end
            cyc++;
        end
        ena = 1'b1;
        check($sformatf("%s.word_count", tag), 32'(got), 32'(n));
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        check($sformatf("%s.no_extra_word", tag), 32'(hvalid), 32'd0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        check({tag, ".rst_hvalid"}, 32'(hvalid), 32'd0);
        check({tag, ".rst_err"},    32'(err),    32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1; idle_inputs();
        size = '0; rlen = '0; amp = '0; tbl_sel = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
        repeat (3) @(negedge clk);
        check("reset.hvalid", 32'(hvalid), 32'd0);
        check("reset.hblk",   32'(hblk),   32'd0);
        check("reset.err",    32'(err),    32'd0);
        check("reset.hcode",  32'(hcode),  32'd0);
        check("reset.hlen",   32'(hlen),   32'd0);
        rst = 1'b1;

        // Table contents used by the vectors below.
        load(TBL_DC, 8'h03, 16'h0004, 5'd3);   // 100
        load(TBL_DC, 8'h00, 16'h0000, 5'd2);   // 00
        load(TBL_DC, 8'h0B, 16'hFFFE, 5'd16);
        load(TBL_DC, 8'h0C, 16'h0001, 5'd2);   // 01
        load(TBL_AC, 8'h01, 16'h0000, 5'd2);   // 00
        load(TBL_AC, 8'h00, 16'h000A, 5'd4);   // EOB 1010
        load(TBL_AC, 8'hF0, 16'h07F9, 5'd11);  // ZRL
        load(TBL_AC, 8'h12, 16'h001B, 5'd5);   // 11011
        load(TBL_AC, 8'h0A, 16'hFF83, 5'd16);
        load(TBL_AC, 8'h02, 16'h0000, 5'd0);   // deliberately zero length
        load(TBL_AC, 8'h0B, 16'h0005, 5'd3);   // 101
        load(TBL_AC, 8'hF1, 16'hFFF5, 5'd16);

        // Main vector table, applied back to back.
        q = {};
        q.push_back(mk(1, 0,  3,    -3, 'h24,      6,  0));
        q.push_back(mk(0, 0,  1,     1, 'h1,       3,  0));
        q.push_back(mk(0, 1,  2,    -2, 'h6D,      7,  0));
        q.push_back(mk(0, 15, 0,     0, 'h7F9,     11, 0));
        q.push_back(mk(0, 0,  0,     0, 'hA,       4,  0));
        q.push_back(mk(1, 0,  0,     0, 'h0,       2,  0));
        q.push_back(mk(0, 0,  1,    -1, 'h0,       3,  0));
        q.push_back(mk(0, 0,  0,     0, 'hA,       4,  0));
        q.push_back(mk(1, 0,  11, 1023, 'h7FFF3FF, 27, 0));
        q.push_back(mk(0, 0,  10, -1023,'h3FE0C00, 26, 0));
        q.push_back(mk(0, 0,  0,     0, 'hA,       4,  0));
        run_stream("vec", -1, 0);

        // Clock-enable stall in the middle of a stream.
        q = {};
        q.push_back(mk(1, 0,  3, -3, 'h24,  6,  0));
        q.push_back(mk(0, 0,  1,  1, 'h1,   3,  0));
        q.push_back(mk(0, 1,  2, -2, 'h6D,  7,  0));
        q.push_back(mk(0, 15, 0,  0, 'h7F9, 11, 0));
        q.push_back(mk(0, 0,  0,  0, 'hA,   4,  0));
        run_stream("stall", 2, 3);

        // Table write colliding with a lookup of the same AC entry.
        q = {};
        q.push_back(mk(1, 0, 3, -3, 'h24, 6, 0));
        q.push_back(mk(0, 0, 1,  1, 'h1,  3, 0));
        q[1].tw = 1'b1; q[1].tw_addr = 8'h01; q[1].tw_code = 16'h0003; q[1].tw_len = 5'd2;
        q.push_back(mk(0, 0, 1,  1, 'h7,  3, 0));
        q.push_back(mk(0, 0, 0,  0, 'hA,  4, 0));
        run_stream("rdw", -1, 0);
        check("no_err_so_far", 32'(err), 32'd0);

        // Zero-length table entry: word still emitted, err set.
        q = {};
        q.push_back(mk(1, 0, 3, -3, 'h24, 6, 0));
        q.push_back(mk(0, 0, 2,  1, 'h1,  2, 1));
        q.push_back(mk(0, 0, 0,  0, 'hA,  4, 1));
        run_stream("len0", -1, 0);
        reset_pulse("len0");

        // AC size 11 exceeds the AC limit.
        q = {};
        q.push_back(mk(1, 0, 3,  -3, 'h24,   6,  0));
        q.push_back(mk(0, 0, 11, -5, 'h2FFA, 14, 1));
        q.push_back(mk(0, 0, 0,   0, 'hA,    4,  1));
        run_stream("acsz", -1, 0);
        reset_pulse("acsz");

        // DC size 12 is clamped to 11 amplitude bits.
        q = {};
        q.push_back(mk(1, 0, 12, 1, 'h801, 13, 1));
        q.push_back(mk(0, 0, 0,  0, 'hA,   4,  1));
        run_stream("dcsz", -1, 0);
        reset_pulse("dcsz");

        // Index overrun: DC, 3 x ZRL (idx 48), then (15,1) -> 64.
        q = {};
        q.push_back(mk(1, 0,  3, -3, 'h24,    6,  0));
        q.push_back(mk(0, 15, 0,  0, 'h7F9,   11, 0));
        q.push_back(mk(0, 15, 0,  0, 'h7F9,   11, 0));
        q.push_back(mk(0, 15, 0,  0, 'h7F9,   11, 0));
        q.push_back(mk(0, 15, 1,  1, 'h1FFEB, 17, CHK));
        run_stream("idx", -1, 0);
        repeat (3) @(negedge clk);
        check("idx.err_sticky", 32'(err), 32'(CHK));
        reset_pulse("idx");

        // Reset with two symbols in flight: nothing may emerge afterwards.
        @(negedge clk);
        den = 1'b1; bstart = 1'b1; size = 4'd3; rlen = 4'd0; amp = 12'hFFD;
        @(negedge clk);
        bstart = 1'b0; size = 4'd1; amp = 12'h001;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        check("midrst.hvalid_now", 32'(hvalid), 32'd0);
        check("midrst.hcode_now",  32'(hcode),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrst.quiet%0d", i), 32'(hvalid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_huff_enc.md
JPEG_HUFF_ENC -- requirements
Module: jpeg_huff_enc

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single system clock; all state is rising-edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port `ena`, input, 1 bit: clock enable; when low, all state holds, including the pipeline, FSM and table writes.
REQ-004 The block SHALL have the symbol inputs `size` (4 bits), `rlen` (4 bits) and `amp` (12 bits, two's complement), taken from the run-length stage.
REQ-005 The block SHALL have the port `den`, input, 1 bit: symbol valid.
REQ-006 The block SHALL have the port `bstart`, input, 1 bit: symbol is the DC term of a new block.
REQ-007 The block SHALL have the table write port: `tbl_we` (1 bit), `tbl_sel` (1 bit, 0=DC, 1=AC), `tbl_addr` (8 bits), `tbl_code` (16 bits), `tbl_len` (5 bits).
REQ-008 The block SHALL have the port `hcode`, output, 27 bits: code followed by amplitude bits, right-aligned; bits at and above `hlen` are 0.
REQ-009 The block SHALL have the port `hlen`, output, 5 bits: total bit count, range 0..27.
REQ-010 The block SHALL have the port `hvalid`, output, 1 bit: `hcode`/`hlen` are valid.
REQ-011 The block SHALL have the port `hblk`, output, 1 bit: this word starts a block.
REQ-012 The block SHALL have the port `err`, output, 1 bit: sticky protocol error flag.

Function
REQ-013 DC lookup: the address SHALL be {4'h0,size}, read from the DC table.
REQ-014 AC lookup: the address SHALL be {rlen,size}, read from the AC table; (0,0) is EOB and (15,0) is ZRL.
REQ-015 Amplitude bits: if amp>=0, take amp[size-1:0]; if amp<0, take (amp-1)[size-1:0]. When size=0, no amplitude bits are appended.
REQ-016 Output fields SHALL be hcode = {code[len-1:0], ampbits[size-1:0]} and hlen = len+size.
REQ-017 Latency SHALL be exactly 2 enabled cycles from den to hvalid; `hblk` SHALL be pipelined alongside `hvalid`; throughput is one symbol per enabled cycle.
REQ-018 A table entry with len=0 SHALL still emit the word (hlen=size) and SHALL set `err`.
REQ-019 On a simultaneous `tbl_we` and `den` to the same entry, the lookup SHALL return the old contents, and the write SHALL take effect for subsequent symbols.
REQ-020 Sizes above 11 (DC) or above 10 (AC) SHALL set `err`, and the encoded `size` SHALL be clamped to 11.

Reset
REQ-021 On `rst` low, the block SHALL asynchronously clear `hvalid`, `hblk`, `err`, `hcode`, `hlen`, the pipeline valid bits, the FSM (to WAIT_DC) and the index counter (to 0).
REQ-022 Table contents SHALL NOT be reset, and they SHALL be loaded before the first symbol.
REQ-023 A reset mid-block SHALL discard in-flight symbols, and no partial word SHALL be output afterwards.

Configuration
REQ-024 With macro JPEG_HUFF_CHK_EN defined, the block SHALL include the block-protocol checker:
- FSM with states WAIT_DC and IN_BLK.
- 6-bit coefficient index `idx`.
REQ-025 The checker SHALL behave as follows:
- WAIT_DC: den with bstart moves to IN_BLK with idx=0; den without bstart sets `err` and the symbol is encoded as AC.
- IN_BLK, non-EOB AC symbol: idx += rlen+1.
- IN_BLK, result above 63: sets `err`.
- IN_BLK, EOB symbol or idx reaching 63 exactly: returns to WAIT_DC.
- IN_BLK, bstart: restarts the block with idx=0 and sets `err`.
REQ-026 Without JPEG_HUFF_CHK_EN, the FSM and counter SHALL be absent, `bstart` alone SHALL select the DC table, and `err` SHALL reflect only REQ-018 and REQ-020.

Structure
REQ-027 Package `jpeg_huff_pkg` SHALL hold the following:
- `huff_ent_t` {code[15:0], len[4:0]}.
- Constants MAX_CODE_LEN=16, MAX_AMP_BITS=11, TBL_DC=0, TBL_AC=1.
- Checker state enum.
REQ-028 Sub-module `jpeg_huff_tbl` SHALL implement the following:
- 16-entry DC and 256-entry AC storage.
- One synchronous write port.
- One registered read port, which provides pipeline stage 1.
REQ-029 Stage 2 (amplitude formatting and concatenation) SHALL reside in `jpeg_huff_enc`.

Verification
REQ-030 The bench SHALL load DC[3]=(3'b100,len 3) and send bstart,size=3,amp=-3; it SHALL check hcode=0x24, hlen=6, hblk=1 two cycles later.
REQ-031 The bench SHALL load AC[0x01]=(2'b00,2) and send rlen=0,size=1,amp=+1; it SHALL check hcode=0x1, hlen=3, hblk=0.
REQ-032 The bench SHALL load AC[0x00]=(4'b1010,4) and AC[0xF0]=(0x7F9,11); it SHALL send EOB and check hcode=0xA, hlen=4, then send ZRL and check hcode=0x7F9, hlen=11.
REQ-033 Under CHK_EN, the bench SHALL send DC, then three ZRL, then (15,1); it SHALL check `err` rises on the (15,1) word, since idx reaches 64, and `err` stays set until reset.
REQ-034 The bench SHALL send back-to-back symbols with `ena` low for 3 cycles mid-stream; it SHALL check the outputs hold, no symbol is dropped or duplicated, and the order is preserved.
REQ-035 The bench SHALL drive tbl_we to AC[0x01] in the same cycle as an AC (0,1) symbol; it SHALL check that symbol uses the old code and the next (0,1) uses the new code.
